pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: tracks post-decode stages and drives stall, bubble and bypass selects.
// Define PIPE_BYPASS_EN to enable bypassing; otherwise any RAW match stalls until it retires.
module pipe_hazard_ctrl #(
   parameter  int STAGES   = 3,
   parameter  int REG_W    = 5,
   parameter  int LOAD_LAT = 1,
   localparam int SEL_W    = $clog2(STAGES + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic [REG_W-1:0]  id_rd,
   input  logic              id_we,
   input  logic              id_load,
   input  logic              flush,
   input  logic              ext_stall,
   output logic              stall,
   output logic              bubble,
   output logic [SEL_W-1:0]  fwd_a_sel,
   output logic [SEL_W-1:0]  fwd_b_sel,
   output logic [STAGES-1:0] stage_valid,
   output logic [31:0]       stall_cycles
);

   logic [STAGES-1:0]            valid_q, valid_d;
   logic [STAGES-1:0]            we_q, we_d;
   logic [STAGES-1:0]            load_q, load_d;
   logic [STAGES-1:0][REG_W-1:0] rd_q, rd_d;
   logic [31:0]                  stall_cycles_q, stall_cycles_d;

   logic [STAGES-1:0] match_a, match_b;
   logic [SEL_W-1:0]  sel_a, sel_b;
   logic              hazard, live_haz, advance, accept;

   always_comb begin
      match_a = '0;
      match_b = '0;
      for (int k = 0; k < STAGES; k++) begin
         match_a[k] = id_rs_used && (id_rs != '0) && valid_q[k] && we_q[k] && (rd_q[k] == id_rs);
         match_b[k] = id_rt_used && (id_rt != '0) && valid_q[k] && we_q[k] && (rd_q[k] == id_rt);
      end
   end

`ifdef PIPE_BYPASS_EN
   logic haz_a, haz_b;

   // Walk from the oldest stage down so the youngest (lowest-index) match wins.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      haz_a = 1'b0;
      haz_b = 1'b0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         if (match_a[k]) begin
            sel_a = SEL_W'(k + 1);
            haz_a = load_q[k] && (k < LOAD_LAT);
         end
         if (match_b[k]) begin
            sel_b = SEL_W'(k + 1);
            haz_b = load_q[k] && (k < LOAD_LAT);
         end
      end
      hazard = id_valid && (haz_a || haz_b);
   end
`else
   logic unused_bypass_cfg;
   assign unused_bypass_cfg = ^{load_q, (LOAD_LAT > 0)};

   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      hazard = id_valid && ((|match_a) || (|match_b));
   end
`endif

   always_comb begin
      live_haz    = reset && hazard;
      stall       = reset && (live_haz || ext_stall) && !flush;
      bubble      = flush || (live_haz && !ext_stall);
      fwd_a_sel   = reset ? sel_a : '0;
      fwd_b_sel   = reset ? sel_b : '0;
      stage_valid = reset ? valid_q : '0;
      stall_cycles = stall_cycles_q;

      // A flush overrides ext_stall so the wrong-path instruction cannot linger in decode.
      advance = !ext_stall || flush;
      accept  = id_valid && !bubble;

      valid_d = valid_q;
      we_d    = we_q;
      load_d  = load_q;
      rd_d    = rd_q;
      if (advance) begin
         valid_d = {valid_q[STAGES-2:0], accept};
         we_d    = {we_q[STAGES-2:0], accept && id_we};
         load_d  = {load_q[STAGES-2:0], accept && id_load};
         rd_d    = {rd_q[STAGES-2:0], (accept ? id_rd : {REG_W{1'b0}})};
      end

      stall_cycles_d = stall_cycles_q;
      if (live_haz && !flush && !ext_stall) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
   end

   always_ff @(negedge clock) begin
      if (!reset) begin
         valid_q        <= '0;
         we_q           <= '0;
         load_q         <= '0;
         rd_q           <= '0;
         stall_cycles_q <= '0;
      end else begin
         valid_q        <= valid_d;
         we_q           <= we_d;
         load_q         <= load_d;
         rd_q           <= rd_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl; expectations cover both PIPE_BYPASS_EN builds.
module tb_pipe_hazard_ctrl;
   localparam int STAGES = 3;
   localparam int REG_W  = 5;
   localparam int SEL_W  = 2;
   localparam int EW     = 2 + 2 * SEL_W + STAGES + 32;
`ifdef PIPE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clock;
   logic              reset;
   logic              id_valid;
   logic [REG_W-1:0]  id_rs, id_rt, id_rd;
   logic              id_rs_used, id_rt_used, id_we, id_load;
   logic              flush, ext_stall;
   logic              stall, bubble;
   logic [SEL_W-1:0]  fwd_a_sel, fwd_b_sel;
   logic [STAGES-1:0] stage_valid;
   logic [31:0]       stall_cycles;

   pipe_hazard_ctrl #(.STAGES(STAGES), .REG_W(REG_W), .LOAD_LAT(1)) dut (
      .clock(clock), .reset(reset), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_rd(id_rd), .id_we(id_we), .id_load(id_load),
      .flush(flush), .ext_stall(ext_stall),
      .stall(stall), .bubble(bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .stage_valid(stage_valid), .stall_cycles(stall_cycles)
   );

   // clock / reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog");
   end

   // mode: 0 = both builds, 1 = bypass build only, 2 = no-bypass build only
   typedef struct {
      int            mode;
      int            r, f, x, v, rs, ru, rt, tu, rd, we, ld;
      logic [EW-1:0] eb;
      logic [EW-1:0] en;
   } vec_t;

   vec_t          vecs[$];
   logic [EW-1:0] exp_q[$];
   int            n_cmp = 0;
   int            n_bad = 0;

   function automatic logic [EW-1:0] ex(input int st, input int bu, input int fa, input int fb,
                                        input int sv, input int cnt);
      return {1'(st), 1'(bu), SEL_W'(fa), SEL_W'(fb), STAGES'(sv), 32'(cnt)};
   endfunction

   // driver tasks
   task automatic drive(input int r, input int f, input int x, input int v, input int rs,
                        input int ru, input int rt, input int tu, input int rd, input int we,
                        input int ld);
      reset      = 1'(r);
      flush      = 1'(f);
      ext_stall  = 1'(x);
      id_valid   = 1'(v);
      id_rs      = REG_W'(rs);
      id_rs_used = 1'(ru);
      id_rt      = REG_W'(rt);
      id_rt_used = 1'(tu);
      id_rd      = REG_W'(rd);
      id_we      = 1'(we);
      id_load    = 1'(ld);
   endtask

   task automatic add_vec(input int m, input int r, input int f, input int x, input int v,
                          input int rs, input int ru, input int rt, input int tu, input int rd,
                          input int we, input int ld, input logic [EW-1:0] eb,
                          input logic [EW-1:0] en);
      vec_t t;
      t.mode = m; t.r = r; t.f = f; t.x = x; t.v = v;
      t.rs = rs; t.ru = ru; t.rt = rt; t.tu = tu; t.rd = rd; t.we = we; t.ld = ld;
      t.eb = eb; t.en = en;
      vecs.push_back(t);
   endtask

   // scoreboard: expectation queued with the stimulus, checked mid-cycle, then one state edge
   task automatic cycle_chk(input string name, input logic [EW-1:0] e);
      logic [EW-1:0] got, want;
      exp_q.push_back(e);
      @(posedge clock);
      #1;
      got  = {stall, bubble, fwd_a_sel, fwd_b_sel, stage_valid, stall_cycles};
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: stall/bubble/fa/fb/sv/cnt got %0b/%0b/%0d/%0d/%b/%0d want %0b/%0b/%0d/%0d/%b/%0d",
                  name, got[40], got[39], got[38:37], got[36:35], got[34:32], got[31:0],
                  want[40], want[39], want[38:37], want[36:35], want[34:32], want[31:0]);
      end
      @(negedge clock);
      #1;
   endtask

   localparam int FA1 = BYP ? 1 : 0;
   localparam int FB3 = BYP ? 3 : 0;

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clock);
      #1;

      // reset behaviour, then add r3 / add r4,r3,r1
      add_vec(0, 0,1,0,1, 3,1,0,0, 0,0,0, ex(0,1,0,0,'b000,0), ex(0,1,0,0,'b000,0));
      add_vec(0, 0,0,0,1, 3,1,0,0, 0,0,0, ex(0,0,0,0,'b000,0), ex(0,0,0,0,'b000,0));
      add_vec(0, 1,0,0,1, 1,1,2,1, 3,1,0, ex(0,0,0,0,'b000,0), ex(0,0,0,0,'b000,0));
      add_vec(1, 1,0,0,1, 3,1,1,1, 4,1,0, ex(0,0,1,0,'b001,0), ex(0,0,0,0,'b000,0));
      add_vec(1, 1,0,0,0, 0,0,0,0, 0,0,0, ex(0,0,0,0,'b011,0), ex(0,0,0,0,'b000,0));
      add_vec(2, 1,0,0,1, 3,1,1,1, 4,1,0, ex(0,0,0,0,'b000,0), ex(1,1,0,0,'b001,0));
      add_vec(2, 1,0,0,1, 3,1,1,1, 4,1,0, ex(0,0,0,0,'b000,0), ex(1,1,0,0,'b010,1));
      add_vec(2, 1,0,0,1, 3,1,1,1, 4,1,0, ex(0,0,0,0,'b000,0), ex(1,1,0,0,'b100,2));
      add_vec(2, 1,0,0,1, 3,1,1,1, 4,1,0, ex(0,0,0,0,'b000,0), ex(0,0,0,0,'b000,3));
      add_vec(0, 0,0,0,0, 0,0,0,0, 0,0,0, ex(0,0,0,0,'b000,0), ex(0,0,0,0,'b000,3));
      // lw r5 / sub r6,r5,r2
      add_vec(0, 1,0,0,1, 0,0,0,0, 5,1,1, ex(0,0,0,0,'b000,0), ex(0,0,0,0,'b000,0));
      add_vec(0, 1,0,0,1, 5,1,2,1, 6,1,0, ex(1,1,1,0,'b001,0), ex(1,1,0,0,'b001,0));
      add_vec(0, 1,0,0,1, 5,1,2,1, 6,1,0, ex(0,0,2,0,'b010,1), ex(1,1,0,0,'b010,1));
      add_vec(1, 1,0,0,0, 0,0,0,0, 0,0,0, ex(0,0,0,0,'b101,1), ex(0,0,0,0,'b000,0));
      add_vec(2, 1,0,0,1, 5,1,2,1, 6,1,0, ex(0,0,0,0,'b000,0), ex(1,1,0,0,'b100,2));
      add_vec(2, 1,0,0,1, 5,1,2,1, 6,1,0, ex(0,0,0,0,'b000,0), ex(0,0,0,0,'b000,3));
      add_vec(0, 0,0,0,0, 0,0,0,0, 0,0,0, ex(0,0,0,0,'b000,1), ex(0,0,0,0,'b000,3));
      // r7 in stages 0 and 2, read on both ports
      add_vec(0, 1,0,0,1, 0,0,0,0, 7,1,0, ex(0,0,0,0,'b000,0), ex(0,0,0,0,'b000,0));
      add_vec(0, 1,0,0,0, 0,0,0,0, 0,0,0, ex(0,0,0,0,'b001,0), ex(0,0,0,0,'b001,0));
      add_vec(0, 1,0,0,1, 0,0,0,0, 7,1,0, ex(0,0,0,0,'b010,0), ex(0,0,0,0,'b010,0));
      add_vec(0, 1,0,0,1, 7,1,7,1, 8,1,0, ex(0,0,1,1,'b101,0), ex(1,1,0,0,'b101,0));
      add_vec(0, 0,0,0,0, 0,0,0,0, 0,0,0, ex(0,0,0,0,'b000,0), ex(0,0,0,0,'b000,1));
      // r0 never matches; only a used port may match
      add_vec(0, 1,0,0,1, 0,0,0,0, 0,1,0, ex(0,0,0,0,'b000,0), ex(0,0,0,0,'b000,0));
      add_vec(0, 1,0,0,1, 0,1,0,1, 9,1,0, ex(0,0,0,0,'b001,0), ex(0,0,0,0,'b001,0));
      add_vec(0, 1,0,0,1, 9,0,9,1, 10,1,0, ex(0,0,0,1,'b011,0), ex(1,1,0,0,'b011,0));
      add_vec(0, 0,0,0,0, 0,0,0,0, 0,0,0, ex(0,0,0,0,'b000,0), ex(0,0,0,0,'b000,1));

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].mode == 0 || (vecs[i].mode == 1 && BYP) || (vecs[i].mode == 2 && !BYP)) begin
            drive(vecs[i].r, vecs[i].f, vecs[i].x, vecs[i].v, vecs[i].rs, vecs[i].ru,
                  vecs[i].rt, vecs[i].tu, vecs[i].rd, vecs[i].we, vecs[i].ld);
            cycle_chk($sformatf("vec%0d", i), BYP ? vecs[i].eb : vecs[i].en);
         end
      end

      // flush during a load-use hazard, then flush together with ext_stall
      drive(1,0,0,1, 0,0,0,0, 5,1,1);  cycle_chk("fl_lw5",        ex(0,0,0,0,'b000,0));
      drive(1,1,0,1, 5,1,2,1, 6,1,0);  cycle_chk("fl_load_use",   ex(0,1,FA1,0,'b001,0));
      drive(1,0,0,0, 0,0,0,0, 0,0,0);  cycle_chk("fl_after",      ex(0,0,0,0,'b010,0));
      drive(1,1,1,1, 0,0,0,0, 10,1,0); cycle_chk("fl_ext_stall",  ex(0,1,0,0,'b100,0));
      drive(1,0,0,0, 0,0,0,0, 0,0,0);  cycle_chk("fl_ext_adv",    ex(0,0,0,0,'b000,0));

      // ext_stall freeze with a load in stage 0, then reset mid-stall
      drive(1,0,0,1, 0,0,0,0, 5,1,1);  cycle_chk("xs_lw5",        ex(0,0,0,0,'b000,0));
      drive(1,0,0,1, 5,1,2,1, 6,1,0);  cycle_chk("xs_hazard",     ex(1,1,FA1,0,'b001,0));
      drive(1,0,0,1, 0,0,0,0, 11,1,1); cycle_chk("xs_lw11",       ex(0,0,0,0,'b010,1));
      for (int c = 0; c < 4; c++) begin
         drive(1,0,1,1, 11,1,5,1, 12,1,0);
         cycle_chk($sformatf("xs_frozen%0d", c), ex(1,0,FA1,FB3,'b101,1));
      end
      drive(0,0,1,1, 11,1,5,1, 12,1,0); cycle_chk("xs_reset",     ex(0,0,0,0,'b000,1));
      drive(1,0,0,0, 0,0,0,0, 0,0,0);   cycle_chk("xs_post_reset",ex(0,0,0,0,'b000,0));

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending entries want 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
